// File: rtl/drive_sequencer_pkg.sv
// rtl/drive_sequencer_pkg.sv - command/state types and gate helpers for drive_sequencer
package drive_pkg;

   typedef enum logic [2:0] {
      CMD_STOP  = 3'd0,
      CMD_FWD   = 3'd1,
      CMD_FWD_L = 3'd2,
      CMD_FWD_R = 3'd3,
      CMD_REV   = 3'd4,
      CMD_REV_L = 3'd5,
      CMD_REV_R = 3'd6
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_BRAKE = 3'd2,
      ST_DEAD  = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      POL_NONE = 2'd0,
      POL_FWD  = 2'd1,
      POL_REV  = 2'd2
   } pol_e;

   // Gate vector order: {left_fwd, left_rev, right_fwd, right_rev}
   localparam logic [3:0] GATES_OFF = 4'b0000;

   function automatic pol_e polarity(input cmd_e cmd);
      case (cmd)
         CMD_FWD, CMD_FWD_L, CMD_FWD_R: return POL_FWD;
         CMD_REV, CMD_REV_L, CMD_REV_R: return POL_REV;
         default:                       return POL_NONE;
      endcase
   endfunction

   // Turning left idles the left wheel, turning right idles the right wheel.
   function automatic logic [3:0] gates(input cmd_e cmd);
      case (cmd)
         CMD_FWD:   return 4'b1010;
         CMD_FWD_L: return 4'b0010;
         CMD_FWD_R: return 4'b1000;
         CMD_REV:   return 4'b0101;
         CMD_REV_L: return 4'b0001;
         CMD_REV_R: return 4'b0100;
         default:   return GATES_OFF;
      endcase
   endfunction

   // One duty step toward the target; never overshoots.
   function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
      if (cur < tgt)
         return cur + 4'd1;
      else if (cur > tgt)
         return cur - 4'd1;
      else
         return cur;
   endfunction

endpackage

// File: rtl/drive_sequencer_tick_gen.sv
// rtl/drive_sequencer_tick_gen.sv - free-running divider producing a one-clock ramp tick
module tick_gen #(
   parameter int TICK_DIV = 50000
) (
   input  logic CLK,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..TICK_DIV-1 and wrap; the tick marks the last count.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (r_cnt == LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/drive_sequencer.sv
// rtl/drive_sequencer.sv - arbitrated, ramped motor command sequencer with safe reversal
module drive_sequencer
   import drive_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int DEAD_TICKS = 4
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       step_en,
   input  logic       iS1,
   input  logic       iS2,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       obstacle,
   input  logic [3:0] speed_sel,
   output logic [3:0] duty,
   output logic       left_fwd,
   output logic       left_rev,
   output logic       right_fwd,
   output logic       right_rev,
   output logic [2:0] state
);

   localparam int DCW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
   localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_TICKS - 1);

   logic           w_tick;
   logic [7:0]     w_async_in;
   logic [7:0]     r_sync1;
   logic [7:0]     r_sync2;
   logic           w_obs, w_step_en, w_s1, w_s2, w_up, w_down, w_left, w_right;
   cmd_e           w_cmd;
   pol_e           w_cmd_pol;
   logic [3:0]     w_target;

   state_e         r_state, w_state_nxt;
   cmd_e           r_cmd, w_cmd_nxt;
   logic [3:0]     r_duty, w_duty_nxt;
   logic [DCW-1:0] r_dead_cnt, w_dead_nxt;
   logic [3:0]     r_gates, w_gates_nxt;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLK  (CLK),
      .rst  (rst),
      .tick (w_tick)
   );

   assign w_async_in = {obstacle, step_en, iS1, iS2, up, down, left, right};

   // Two-flop synchronizer for every single-bit control input.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_async_in;
         r_sync2 <= r_sync1;
      end
   end

   assign {w_obs, w_step_en, w_s1, w_s2, w_up, w_down, w_left, w_right} = r_sync2;

   // Decode the synced inputs into a single drive command.
   always_comb begin
      w_cmd = CMD_STOP;
      if (w_step_en) begin
         case ({w_s1, w_s2})
            2'b00:   w_cmd = CMD_FWD;
            2'b01:   w_cmd = CMD_FWD_R;
            2'b10:   w_cmd = CMD_FWD_L;
            default: w_cmd = CMD_STOP;
         endcase
      end else begin
         case ({w_up, w_down, w_left, w_right})
            4'b1000: w_cmd = CMD_FWD;
            4'b1010: w_cmd = CMD_FWD_L;
            4'b1001: w_cmd = CMD_FWD_R;
            4'b0100: w_cmd = CMD_REV;
            4'b0110: w_cmd = CMD_REV_L;
            4'b0101: w_cmd = CMD_REV_R;
            default: w_cmd = CMD_STOP;
         endcase
      end
   end

   assign w_cmd_pol = polarity(w_cmd);
   assign w_target  = (w_cmd != CMD_STOP) ? speed_sel : 4'd0;

   // State, applied command, duty, dead counter and gates share one register stage.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cmd      <= CMD_STOP;
         r_duty     <= 4'd0;
         r_dead_cnt <= '0;
         r_gates    <= GATES_OFF;
      end else begin
         r_state    <= w_state_nxt;
         r_cmd      <= w_cmd_nxt;
         r_duty     <= w_duty_nxt;
         r_dead_cnt <= w_dead_nxt;
         r_gates    <= w_gates_nxt;
      end
   end

   // Next state: obstacle beats reversal beats steering beats ramping.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_nxt   = r_cmd;
      w_duty_nxt  = r_duty;
      w_dead_nxt  = r_dead_cnt;

      if (w_obs) begin
         w_state_nxt = ST_HALT;
         w_duty_nxt  = 4'd0;
         w_dead_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_duty_nxt = 4'd0;
               if (w_cmd != CMD_STOP) begin
                  w_state_nxt = ST_RUN;
                  w_cmd_nxt   = w_cmd;
               end
            end
            ST_RUN: begin
               if ((w_cmd_pol != POL_NONE) && (w_cmd_pol != polarity(r_cmd))) begin
                  w_state_nxt = ST_BRAKE;
               end else if ((w_cmd != CMD_STOP) && (w_cmd != r_cmd)) begin
                  w_cmd_nxt = w_cmd;
               end else if ((w_cmd == CMD_STOP) && (r_duty == 4'd0)) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_tick) begin
                  w_duty_nxt = step_toward(r_duty, w_target);
               end
            end
            ST_BRAKE: begin
               if (r_duty == 4'd0) begin
                  w_state_nxt = ST_DEAD;
                  w_dead_nxt  = '0;
               end else if (w_tick) begin
                  w_duty_nxt = r_duty - 4'd1;
               end
            end
            ST_DEAD: begin
               w_duty_nxt = 4'd0;
               if (w_tick) begin
                  if (r_dead_cnt == DEAD_LAST) begin
                     w_dead_nxt = '0;
                     if (w_cmd == CMD_STOP) begin
                        w_state_nxt = ST_IDLE;
                     end else begin
                        w_state_nxt = ST_RUN;
                        w_cmd_nxt   = w_cmd;
                     end
                  end else begin
                     w_dead_nxt = r_dead_cnt + DCW'(1);
                  end
               end
            end
            ST_HALT: begin
               w_duty_nxt = 4'd0;
               if (w_cmd == CMD_STOP)
                  w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_duty_nxt  = 4'd0;
               w_dead_nxt  = '0;
            end
         endcase
      end

      // Gates drive only while running or braking against the held command.
      if ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_BRAKE))
         w_gates_nxt = gates(w_cmd_nxt);
      else
         w_gates_nxt = GATES_OFF;
   end

   assign duty = r_duty;
   assign state = r_state;
   assign {left_fwd, left_rev, right_fwd, right_rev} = r_gates;

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Motion controller that sits between the operator/line-sensor inputs and the PWM and H-bridge stage of the car. It arbitrates between manual buttons, line-follow sensors and an obstacle stop, then emits a ramped 4-bit duty value for `pwm` plus four per-wheel direction gates, which the top level ANDs with the PWM wave to drive IN1..IN4. Reversals are sequenced as brake-to-zero, then dead time, then ramp-up. This protects the H-bridge and the gearbox.

## Interface
- `TICK_DIV`, 50000: clocks per ramp/dead-time tick (≥2).
- `DEAD_TICKS`, 4: ticks with all gates off between opposite polarities (≥1).
- `CLK` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `step_en` in 1: 1 = line-follow mode (`iS1`/`iS2`), 0 = manual mode (`up`/`down`/`left`/`right`).
- `iS1`, `iS2` in 1 each: line sensors.
- `up`, `down`, `left`, `right` in 1 each: manual buttons.
- `obstacle` in 1: emergency stop request.
- `speed_sel` in 4: target duty, 0..15.
- `duty` out 4: pulse width to `pwm`.
- `left_fwd`, `left_rev`, `right_fwd`, `right_rev` out 1 each: wheel direction gates.
- `state` out 3: current FSM state, for debug/display.

## Operation
- All single-bit inputs pass through a 2-flop synchronizer. `speed_sel` is sampled directly; it is quasi-static.
- Command decode (combinational, on synced inputs):
  - Manual: `up` only → FWD. `up`+`left` → FWD_L. `up`+`right` → FWD_R. `down` only → REV. `down`+`left` → REV_L. `down`+`right` → REV_R. Any other combination → STOP.
  - Line mode (iS1,iS2): 00 → FWD, 01 → FWD_R, 10 → FWD_L, 11 → STOP.
- Gate map for the applied command:
  - FWD: `left_fwd`, `right_fwd`.
  - FWD_L: `right_fwd` only. FWD_R: `left_fwd` only.
  - REV: `left_rev`, `right_rev`.
  - REV_L: `right_rev` only. REV_R: `left_rev` only.
  - A `*_fwd` and `*_rev` gate are never high together.
- Polarity: FWD* = forward, REV* = reverse, STOP = none.
- Target duty = `speed_sel` when the command is not STOP, else 0.
- `duty` steps by exactly 1 per tick toward the target and never overshoots.
- States:
  - IDLE: `duty`=0, gates 0. A non-STOP command latches as the applied command and moves to RUN.
  - RUN: gates follow the applied command. `duty` ramps toward the target.
    - Same-polarity steering change: the applied command updates on the next clock; `duty` is untouched.
    - Opposite polarity: go to BRAKE.
    - Command STOP and `duty`=0: go to IDLE.
  - BRAKE: gates hold the old applied command. `duty` decrements per tick; at 0, go to DEAD.
  - DEAD: gates 0, `duty` 0. Count `DEAD_TICKS` ticks, then go to RUN with the applied command set to the current command, or to IDLE if the command is STOP.
  - HALT: `duty`=0 and gates 0 immediately. Entered from any state whenever synced `obstacle`=1. Exit to IDLE only when `obstacle`=0 and the command is STOP, so the operator must release the controls.

## Timing
- Reset values: `duty`=0, all gates 0, `state`=IDLE, tick and dead counters 0.
- All outputs are registered. Input-to-output latency is 2 sync clocks plus 1 register clock.
- Tick generator is free-running: counts 0..`TICK_DIV`-1 and emits a 1-clock pulse at wrap. Ramp and dead counters advance only on tick.
- Full-scale ramp 0→15 takes 15 ticks. First step timing depends on tick phase, jitter ≤1 tick.
- Priority in the same clock: `obstacle` > reversal > steering > ramp.
- `speed_sel` change mid-ramp retargets; if the new target is below `duty`, `duty` ramps down.
- `speed_sel`=0 with a motion command: stay in RUN, gates asserted, `duty` 0.
- Reversal request during DEAD: latched at DEAD exit; DEAD is not restarted.
- Mode switch via `step_en` mid-run is treated as an ordinary command change.
- `rst` asserted mid-ramp clears all state asynchronously; outputs go to 0 without waiting for a clock.

## Structure
- Package `drive_pkg` holds:
  - cmd enum (3 bits: STOP, FWD, FWD_L, FWD_R, REV, REV_L, REV_R).
  - state enum (IDLE, RUN, BRAKE, DEAD, HALT).
  - functions `polarity(cmd)` and `gates(cmd)`.
- One sub-module, `tick_gen` (parameter `TICK_DIV`, outputs the `tick` pulse).
- Synchronizer, decoder and FSM live inline.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEAD_TICKS`=2.
- Reset: hold `rst` with `up`=1 → `duty`=0, gates 0, `state`=IDLE. After release, RUN within 3 clocks.
- Ramp: `up`=1, `speed_sel`=10 → `left_fwd`=`right_fwd`=1. `duty` rises 1 per 4 clocks, reaches 10 within 44 clocks, then holds.
- Reversal: at FWD `duty`=10, set `down`=1, `up`=0 → BRAKE with fwd gates held, `duty` 10→0 over 10 ticks. Then DEAD: 2 ticks with all gates 0. Then `left_rev`=`right_rev`=1 and ramp to 10.
- Steering: RUN FWD at `duty`=10, add `left`=1 → `right_fwd`=1 and `left_fwd`=0 three clocks later; `duty` stays 10.
- Obstacle: pulse `obstacle` mid-ramp → HALT, `duty`=0, gates 0. Remains HALT while `up` is held after `obstacle` drops. IDLE once `up` is released.
- Line mode: `step_en`=1, iS=00, `speed_sel`=15 → FWD ramp to 15. Change `speed_sel` to 5 → `duty` ramps to 5. Set iS=11 → ramp to 0, then IDLE.
